// File: rtl/mf_clken_pkg.sv
// rtl/mf_clken_pkg.sv - shared types and constants for the fractional clock-enable generator
package mf_clken_pkg;

  localparam int ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Reason a config request was refused; ERR_NONE means it is applied.
  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_MOD_ZERO   = 3'd1,
    ERR_INC_GT_MOD = 3'd2,
    ERR_BAD_CHAN   = 3'd3,
    ERR_PHASE      = 3'd4
  } cfg_err_t;

endpackage

// File: rtl/mf_clken_ch.sv
// rtl/mf_clken_ch.sv - one fractional accumulator channel (phase preload under MF_CLKEN_PHASE_EN)
module mf_clken_ch
  import mf_clken_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             reload,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_mod,
  input  logic [ACC_W-1:0] load_phase,
  output logic             ce
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] mod_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] reload_val;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_wrap;

`ifdef MF_CLKEN_PHASE_EN
  logic [ACC_W-1:0] phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else if (load) begin
      phase_q <= load_phase;
    end
  end

  // A load reloads from the phase being written, not the stale one.
  assign reload_val = load ? load_phase : phase_q;
`else
  logic unused_phase;
  assign unused_phase = ^load_phase;
  assign reload_val   = '0;
`endif

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};
  // inc <= mod keeps sum - mod below mod, so the low ACC_W bits are exact.
  assign acc_wrap = sum[ACC_W-1:0] - mod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q <= '0;
      mod_q <= ACC_W'(1);
      acc_q <= '0;
      ce    <= 1'b0;
    end else begin
      if (load) begin
        inc_q <= load_inc;
        mod_q <= load_mod;
      end
      if (load || reload || !run) begin
        acc_q <= reload_val;
        ce    <= 1'b0;
      end else if (sum >= {1'b0, mod_q}) begin
        acc_q <= acc_wrap;
        ce    <= 1'b1;
      end else begin
        acc_q <= sum[ACC_W-1:0];
        ce    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mf_clken_gen.sv
// rtl/mf_clken_gen.sv - N-channel fractional clock-enable generator with lock/settle gating
// Optional per-channel phase preload: define MF_CLKEN_PHASE_EN.
module mf_clken_gen
  import mf_clken_pkg::*;
#(
  parameter  int NUM_CH     = 5,
  parameter  int ACC_W      = ACC_W_DEF,
  parameter  int SETTLE_CYC = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_mod,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked
);

  localparam int              CNT_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CH_W:0]    NUM_CH_C    = (CH_W + 1)'(NUM_CH);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  settle_cnt;
  logic              run;
  logic              accept;
  logic              cfg_ok;
  cfg_err_t          cause;
  logic [NUM_CH-1:0] load_vec;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_LOCK: if (pll_locked) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!pll_locked)                     state_d = ST_WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST)  state_d = ST_RUN;
      end
      ST_RUN:       if (!pll_locked) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_WAIT_LOCK;
    endcase
  end

  // Counts only uninterrupted locked cycles spent in SETTLE.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state_q == ST_SETTLE && pll_locked) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  assign locked = (state_q == ST_RUN);
  // Channels stop stepping on the same edge the FSM leaves RUN.
  assign run    = (state_q == ST_RUN) && pll_locked;

  always_comb begin
    cause = ERR_NONE;
    if (cfg_mod == '0) begin
      cause = ERR_MOD_ZERO;
    end else if (cfg_inc > cfg_mod) begin
      cause = ERR_INC_GT_MOD;
    end else if ({1'b0, cfg_chan} >= NUM_CH_C) begin
      cause = ERR_BAD_CHAN;
`ifdef MF_CLKEN_PHASE_EN
    end else if (cfg_phase >= cfg_mod) begin
      cause = ERR_PHASE;
`endif
    end
  end

  assign accept = cfg_valid && cfg_ready;
  assign cfg_ok = accept && (cause == ERR_NONE);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      cfg_err   <= accept && (cause != ERR_NONE);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_vec[i] = cfg_ok && (cfg_chan == CH_W'(i));

    mf_clken_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk        (refclk),
      .rst        (rst),
      .run        (run),
      .reload     (sync_all),
      .load       (load_vec[i]),
      .load_inc   (cfg_inc),
      .load_mod   (cfg_mod),
      .load_phase (cfg_phase),
      .ce         (ce_out[i])
    );
  end

endmodule

// File: tb/tb_mf_clken_gen.sv
// tb/tb_mf_clken_gen.sv - randomized self-checking bench for mf_clken_gen against a rate model
module tb_mf_clken_gen;

  localparam int NUM_CH     = 5;
  localparam int ACC_W      = 24;
  localparam int SETTLE_CYC = 40;
  localparam int CH_W       = 3;
`ifdef MF_CLKEN_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              pll_locked = 1'b0;
  logic              sync_all = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan = '0;
  logic [ACC_W-1:0]  cfg_inc = '0;
  logic [ACC_W-1:0]  cfg_mod = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] ce_out;
  logic              locked;

  mf_clken_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sync_all   (sync_all),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_inc    (cfg_inc),
    .cfg_mod    (cfg_mod),
    .cfg_phase  (cfg_phase),
    .cfg_err    (cfg_err),
    .ce_out     (ce_out),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: each channel tracks the unbounded position phase + k*inc since its
  // last reload; a pulse is a crossing of a multiple of mod.
  longint unsigned m_inc [NUM_CH];
  longint unsigned m_mod [NUM_CH];
  longint unsigned m_ph  [NUM_CH];
  longint unsigned m_pos [NUM_CH];
  bit              m_ce  [NUM_CH];
  bit              m_locked, m_ready, m_err;
  int              lock_n;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_inc[i] = 0; m_mod[i] = 1; m_ph[i] = 0; m_pos[i] = 0; m_ce[i] = 0;
    end
    m_locked = 0; m_ready = 1; m_err = 0; lock_n = 0;
  endtask

  function automatic logic [NUM_CH+2:0] exp_out();
    logic [NUM_CH+2:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i+3] = m_ce[i];
    v[2] = m_locked; v[1] = m_ready; v[0] = m_err;
    return v;
  endfunction

  // Advance model by one edge using the inputs currently driven, then clock DUT.
  task automatic step();
    bit run_now, accept, bad, ld;
    longint unsigned old;
    run_now = m_locked && pll_locked;
    accept  = cfg_valid && m_ready;
    bad = (cfg_mod == 0) || (cfg_inc > cfg_mod) || (int'(cfg_chan) >= NUM_CH) ||
          (PH_EN && (cfg_phase >= cfg_mod));
    for (int i = 0; i < NUM_CH; i++) begin
      ld = accept && !bad && (int'(cfg_chan) == i);
      if (ld) begin
        m_inc[i] = cfg_inc; m_mod[i] = cfg_mod; m_ph[i] = PH_EN ? cfg_phase : 0;
      end
      if (ld || sync_all || !run_now) begin
        m_pos[i] = m_ph[i]; m_ce[i] = 0;
      end else begin
        old = m_pos[i];
        m_pos[i] = m_pos[i] + m_inc[i];
        m_ce[i] = (m_pos[i] / m_mod[i]) != (old / m_mod[i]);
      end
    end
    m_err   = accept && bad;
    m_ready = !accept;
    lock_n  = pll_locked ? lock_n + 1 : 0;
    m_locked = (lock_n >= SETTLE_CYC + 1);
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cfg_valid = 0; sync_all = 0; pll_locked = 0;
    repeat (2) @(posedge refclk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic send_cfg(input int ch, input longint unsigned inc, input longint unsigned md,
                          input longint unsigned ph);
    if (!m_ready) step();
    cfg_chan = ch[CH_W-1:0]; cfg_inc = inc[ACC_W-1:0];
    cfg_mod = md[ACC_W-1:0]; cfg_phase = ph[ACC_W-1:0];
    cfg_valid = 1;
    step();
    cfg_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (ce_out !== '0) begin n_fail++; $display("FAIL reset_ce got=%b want=0", ce_out); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b want=0", locked); end
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", cfg_err); end
    n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
  endtask

  task automatic test_lock();
    int rise;
    rise = -1;
    pll_locked = 1;
    for (int i = 1; i <= SETTLE_CYC + 4; i++) begin
      step();
      if (locked === 1'b1 && rise < 0) rise = i;
      n_chk++;
      if (ce_out !== '0) begin n_fail++; $display("FAIL lock_ce cyc=%0d got=%b want=0", i, ce_out); end
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL lock_model cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
    end
    n_chk++;
    if (rise != SETTLE_CYC + 1) begin n_fail++; $display("FAIL lock_rise got=%0d want=%0d", rise, SETTLE_CYC + 1); end
  endtask

  task automatic test_rate();
    int cnt0, cnt2, last0;
    send_cfg(0, 8, 99, 0);
    send_cfg(2, 64, 99, 0);
    sync_all = 1; step(); sync_all = 0;
    cnt0 = 0; cnt2 = 0; last0 = -1;
    for (int i = 1; i <= 198; i++) begin
      step();
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL rate_model cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
      if (i <= 99) begin cnt0 += int'(ce_out[0]); cnt2 += int'(ce_out[2]); end
      if (ce_out[0]) begin
        if (last0 >= 0) begin
          n_chk++;
          if (i - last0 != 12 && i - last0 != 13)
            begin n_fail++; $display("FAIL rate_spacing got=%0d want=12or13", i - last0); end
        end
        last0 = i;
      end
    end
    n_chk++; if (cnt0 != 8) begin n_fail++; $display("FAIL rate_ch0 got=%0d want=8", cnt0); end
    n_chk++; if (cnt2 != 64) begin n_fail++; $display("FAIL rate_ch2 got=%0d want=64", cnt2); end
  endtask

  task automatic test_phase();
    int f0, f1, lead_want;
    lead_want = PH_EN ? 6 : 0;
    send_cfg(0, 8, 99, 0);
    send_cfg(1, 8, 99, 49);
    step();
    sync_all = 1; step(); sync_all = 0;
    f0 = -1; f1 = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL phase_model cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
      if (ce_out[0] && f0 < 0) f0 = i;
      if (ce_out[1] && f1 < 0) f1 = i;
    end
    n_chk++;
    if (f0 - f1 != lead_want || f0 != 13)
      begin n_fail++; $display("FAIL phase_lead got=%0d (ch0 at %0d) want=%0d (ch0 at 13)", f0 - f1, f0, lead_want); end
  endtask

  task automatic test_reject();
    int bch [3];
    longint unsigned binc [3], bmod [3];
    bch[0] = 3; binc[0] = 1;   bmod[0] = 0;
    bch[1] = 3; binc[1] = 100; bmod[1] = 99;
    bch[2] = 7; binc[2] = 1;   bmod[2] = 2;
    for (int k = 0; k < 3; k++) begin
      send_cfg(bch[k], binc[k], bmod[k], 0);
      n_chk++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b0)
        begin n_fail++; $display("FAIL reject_pulse k=%0d got err=%b rdy=%b want err=1 rdy=0", k, cfg_err, cfg_ready); end
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL reject_model k=%0d got=%b want=%b", k, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
      step();
      n_chk++;
      if (cfg_err !== 1'b0 || cfg_ready !== 1'b1)
        begin n_fail++; $display("FAIL reject_after k=%0d got err=%b rdy=%b want err=0 rdy=1", k, cfg_err, cfg_ready); end
    end
    for (int i = 0; i < 60; i++) begin
      step();
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL reject_run cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
    end
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1;
    for (int i = 0; i < 40; i++) begin
      cfg_chan  = CH_W'($urandom_range(0, 7));
      cfg_mod   = ACC_W'($urandom_range(0, 120));
      cfg_inc   = ACC_W'($urandom_range(0, 130));
      cfg_phase = ACC_W'($urandom_range(0, 130));
      sync_all  = ($urandom_range(0, 7) == 0);
      step();
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL b2b_cfg cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
    end
    cfg_valid = 0; sync_all = 0;
    send_cfg(3, 24'hFFFFF0, 24'hFFFFFF, 24'h800000);
    for (int i = 0; i < 300; i++) begin
      sync_all = ($urandom_range(0, 63) == 0);
      step();
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
        begin n_fail++; $display("FAIL b2b_run cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
    end
    sync_all = 0;
  endtask

  task automatic test_lock_loss();
    int rise, first;
    send_cfg(0, 8, 99, 0);
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(3, 20)) step();
      pll_locked = 0;
      step();
      n_chk++;
      if (locked !== 1'b0 || ce_out !== '0)
        begin n_fail++; $display("FAIL loss_drop r=%0d got locked=%b ce=%b want 0", r, locked, ce_out); end
      pll_locked = 1;
      rise = -1; first = -1;
      for (int i = 1; i <= SETTLE_CYC + 30; i++) begin
        step();
        n_chk++;
        if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out())
          begin n_fail++; $display("FAIL loss_model r=%0d cyc=%0d got=%b want=%b", r, i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
        if (locked === 1'b1 && rise < 0) rise = i;
        if (rise > 0 && ce_out[0] && first < 0) first = i - rise;
      end
      n_chk++;
      if (rise != SETTLE_CYC + 1) begin n_fail++; $display("FAIL loss_relock r=%0d got=%0d want=%0d", r, rise, SETTLE_CYC + 1); end
      n_chk++;
      if (first != 13) begin n_fail++; $display("FAIL loss_phase r=%0d got=%0d want=13", r, first); end
    end
  endtask

  task automatic test_reset_async();
    send_cfg(4, 5, 5, 0);
    repeat (3) step();
    n_chk++;
    if (ce_out[4] !== 1'b1) begin n_fail++; $display("FAIL async_pre got=%b want=1", ce_out[4]); end
    #2 rst = 1;
    #1;
    n_chk++;
    if ({ce_out, locked, cfg_ready, cfg_err} !== {{NUM_CH{1'b0}}, 3'b010})
      begin n_fail++; $display("FAIL async_reset got=%b want=%b", {ce_out, locked, cfg_ready, cfg_err}, {{NUM_CH{1'b0}}, 3'b010}); end
    repeat (2) @(posedge refclk);
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < SETTLE_CYC + 60; i++) begin
      step();
      n_chk++;
      if ({ce_out, locked, cfg_ready, cfg_err} !== exp_out() || ce_out !== '0)
        begin n_fail++; $display("FAIL async_after cyc=%0d got=%b want=%b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_out()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_rate();
    test_phase();
    test_reject();
    test_back_to_back();
    test_lock_loss();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
